// File: rtl/fu_alu_pipe_if.sv
// Issue/result handshake bundle for the pipelined integer ALU FU.
// The RS/PRF side and the CDB arbiter side share one valid/ready channel set.
interface fu_alu_pipe_if #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   ps1_data;
  logic [XLEN-1:0]   ps2_data;
  logic [PREG_W-1:0] pd;
  logic [ROB_W-1:0]  rob_idx;
  logic              out_valid;
  logic              out_ready;
  logic [PREG_W-1:0] out_pd;
  logic [ROB_W-1:0]  out_rob;
  logic [XLEN-1:0]   out_data;

  modport master (
    output issue_valid, opcode, func3, func7,
    output imm, pc, ps1_data, ps2_data,
    output pd, rob_idx, out_ready,
    input  issue_ready, out_valid,
    input  out_pd, out_rob, out_data
  );

  modport slave (
    input  issue_valid, opcode, func3, func7,
    input  imm, pc, ps1_data, ps2_data,
    input  pd, rob_idx, out_ready,
    output issue_ready, out_valid,
    output out_pd, out_rob, out_data
  );
endinterface

// File: rtl/fu_alu_pipe.sv
// Elastic multi-stage RV32I integer ALU functional unit.
// Result is computed before stage 1; later stages only carry it.
module fu_alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fu_alu_pipe_if.slave  io
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
  } alu_st_t;

  logic [XLEN-1:0] a, b, res_d;
  logic [SHW-1:0]  sh;
  logic            is_op, is_opi;
  logic            is_lui, is_auipc;
  logic            alt;
  logic            unused_f7;

  assign unused_f7 = ^{io.func7[6], io.func7[4:0]};

  always_comb begin
    is_op    = io.opcode == OPC_OP;
    is_opi   = io.opcode == OPC_OPI;
    is_lui   = io.opcode == OPC_LUI;
    is_auipc = io.opcode == OPC_AUIPC;
    alt      = io.func7[5];
    a        = io.ps1_data;
    b        = is_op ? io.ps2_data : io.imm;
    sh       = b[SHW-1:0];
    res_d    = '0;
    unique case (1'b1)
      is_lui:   res_d = io.imm;
      is_auipc: res_d = io.pc + io.imm;
      is_op, is_opi: begin
        case (io.func3)
          3'b000: res_d = (is_op && alt) ? a - b : a + b;
          3'b001: res_d = a << sh;
          3'b010: res_d = XLEN'($signed(a) < $signed(b));
          3'b011: res_d = XLEN'(a < b);
          3'b100: res_d = a ^ b;
          3'b101: res_d = alt ? $unsigned($signed(a) >>> sh)
                              : a >> sh;
          3'b110: res_d = a | b;
          3'b111: res_d = a & b;
        endcase
      end
      default:  res_d = '0;
    endcase
  end

  alu_st_t           st_q [STAGES];
  alu_st_t           in_s;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;

  assign in_s = '{pd: io.pd, rob: io.rob_idx, data: res_d};

  // A stage moves when any stage at or after it is empty, or the sink takes.
  always_comb begin
    logic acc;
    adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      acc = io.out_ready;
      for (int j = i; j < STAGES; j++) begin
        acc = acc | ~v_q[j];
      end
      adv[i] = acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      if (adv[0] && io.issue_valid) begin
        st_q[0] <= in_s;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i] && v_q[i-1]) begin
          st_q[i] <= st_q[i-1];
        end
      end
      if (flush) begin
        v_q <= '0;
      end else begin
        if (adv[0]) begin
          v_q[0] <= io.issue_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
          if (adv[i]) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end
    end
  end

  assign io.issue_ready = adv[0];
  assign io.out_valid   = v_q[STAGES-1];
  assign io.out_pd      = st_q[STAGES-1].pd;
  assign io.out_rob     = st_q[STAGES-1].rob;
  assign io.out_data    = st_q[STAGES-1].data;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed bench for fu_alu_pipe: 32-bit/2-stage and 64-bit/4-stage copies.
module tb_fu_alu_pipe;
  localparam logic [6:0] OPI   = 7'h13;
  localparam logic [6:0] OP    = 7'h33;
  localparam logic [6:0] LUI   = 7'h37;
  localparam logic [6:0] AUIPC = 7'h17;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fu_alu_pipe_if #(.XLEN(32), .PREG_W(7), .ROB_W(4)) ia ();
  fu_alu_pipe_if #(.XLEN(64), .PREG_W(7), .ROB_W(4)) ib ();

  fu_alu_pipe #(
    .XLEN(32), .STAGES(2), .PREG_W(7), .ROB_W(4)
  ) u_a (
    .clk(clk), .reset(reset), .flush(flush), .io(ia.slave)
  );

  fu_alu_pipe #(
    .XLEN(64), .STAGES(4), .PREG_W(7), .ROB_W(4)
  ) u_b (
    .clk(clk), .reset(reset), .flush(flush), .io(ib.slave)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic iss_a(input logic [6:0]  op,
                       input logic [2:0]  f3,
                       input logic [6:0]  f7,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] im,
                       input logic [6:0]  d,
                       input logic [3:0]  r);
    ia.issue_valid = 1'b1;
    ia.opcode      = op;
    ia.func3       = f3;
    ia.func7       = f7;
    ia.ps1_data    = a;
    ia.ps2_data    = b;
    ia.imm         = im;
    ia.pd          = d;
    ia.rob_idx     = r;
  endtask

  task automatic iss_b(input logic [2:0]  f3,
                       input logic [63:0] a,
                       input logic [63:0] im,
                       input logic [6:0]  d,
                       input logic [3:0]  r);
    ib.issue_valid = 1'b1;
    ib.opcode      = OPI;
    ib.func3       = f3;
    ib.func7       = 7'h00;
    ib.ps1_data    = a;
    ib.ps2_data    = 64'h0;
    ib.imm         = im;
    ib.pd          = d;
    ib.rob_idx     = r;
  endtask

  initial begin
    tv[0]  = '{OPI, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h77, 32'h1, 32'h1};
    tv[1]  = '{OPI, 3'b010, 7'h00, 32'h1, 32'h77, 32'hFFFF_FFFF, 32'h0};
    tv[2]  = '{OPI, 3'b011, 7'h00, 32'h1, 32'h77, 32'hFFFF_FFFF, 32'h1};
    tv[3]  = '{OPI, 3'b101, 7'h00, 32'h8000_0000, 32'h77, 32'h4,
               32'h0800_0000};
    tv[4]  = '{OPI, 3'b101, 7'h20, 32'h8000_0000, 32'h77, 32'h401,
               32'hC000_0000};
    tv[5]  = '{OPI, 3'b001, 7'h00, 32'h3, 32'h77, 32'h22, 32'hC};
    tv[6]  = '{OPI, 3'b100, 7'h00, 32'h0F0F, 32'h77, 32'hFFFF_FFFF,
               32'hFFFF_F0F0};
    tv[7]  = '{OPI, 3'b110, 7'h00, 32'h1200, 32'h77, 32'h34, 32'h1234};
    tv[8]  = '{OPI, 3'b111, 7'h00, 32'hFF0F, 32'h77, 32'h0FF0, 32'h0F00};
    tv[9]  = '{OPI, 3'b000, 7'h20, 32'h5, 32'h77, 32'h3, 32'h8};
    tv[10] = '{OP, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h0, 32'h5A5A, 32'h1};
    tv[11] = '{OP, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'h0, 32'h5A5A, 32'h0};
    tv[12] = '{OP, 3'b101, 7'h00, 32'h8000_0000, 32'h3F, 32'h5A5A, 32'h1};
    tv[13] = '{OP, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'h2, 32'h5A5A, 32'h1};
    tv[14] = '{OP, 3'b000, 7'h20, 32'h0, 32'h1, 32'h5A5A, 32'hFFFF_FFFF};
    tv[15] = '{OP, 3'b111, 7'h00, 32'hF0F0, 32'hFF00, 32'h5A5A, 32'hF000};
    tv[16] = '{OP, 3'b001, 7'h00, 32'h1, 32'h24, 32'h5A5A, 32'h10};

    ia.issue_valid = 1'b0; ia.opcode = '0; ia.func3 = '0;
    ia.func7 = '0; ia.imm = '0; ia.pc = '0; ia.ps1_data = '0;
    ia.ps2_data = '0; ia.pd = '0; ia.rob_idx = '0; ia.out_ready = 1'b1;
    ib.issue_valid = 1'b0; ib.opcode = '0; ib.func3 = '0;
    ib.func7 = '0; ib.imm = '0; ib.pc = '0; ib.ps1_data = '0;
    ib.ps2_data = '0; ib.pd = '0; ib.rob_idx = '0; ib.out_ready = 1'b1;

    // reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(ia.out_valid), 64'h0);
    chk("rst_data", 64'(ia.out_data), 64'h0);
    chk("rst_pd", 64'(ia.out_pd), 64'h0);
    chk("rst_rob", 64'(ia.out_rob), 64'h0);
    chk("rst_irdy", 64'(ia.issue_ready), 64'h1);
    chk("rst_b_valid", 64'(ib.out_valid), 64'h0);
    tick;
    tick;
    reset = 1'b1;
    tick;

    // ADDI latency
    iss_a(OPI, 3'b000, 7'h00, 32'h5, 32'h0, 32'hFFFF_FFFD, 7'd12, 4'd3);
    tick;
    chk("addi_early", 64'(ia.out_valid), 64'h0);
    ia.issue_valid = 1'b0;
    tick;
    chk("addi_valid", 64'(ia.out_valid), 64'h1);
    chk("addi_data", 64'(ia.out_data), 64'h2);
    chk("addi_pd", 64'(ia.out_pd), 64'd12);
    chk("addi_rob", 64'(ia.out_rob), 64'd3);
    tick;
    chk("addi_gone", 64'(ia.out_valid), 64'h0);

    // back-to-back SUB, SRA, SLTU
    iss_a(OP, 3'b000, 7'h20, 32'h7, 32'h9, 32'h0, 7'd1, 4'd1);
    tick;
    iss_a(OP, 3'b101, 7'h20, 32'h8000_0000, 32'h4, 32'h0, 7'd2, 4'd2);
    tick;
    chk("b2b_sub", 64'(ia.out_data), 64'hFFFF_FFFE);
    chk("b2b_sub_rob", 64'(ia.out_rob), 64'd1);
    iss_a(OP, 3'b011, 7'h00, 32'h1, 32'hFFFF_FFFF, 32'h0, 7'd3, 4'd3);
    tick;
    chk("b2b_sra", 64'(ia.out_data), 64'hF800_0000);
    chk("b2b_sra_rob", 64'(ia.out_rob), 64'd2);
    ia.issue_valid = 1'b0;
    tick;
    chk("b2b_sltu", 64'(ia.out_data), 64'h1);
    chk("b2b_sltu_v", 64'(ia.out_valid), 64'h1);
    tick;
    chk("b2b_idle", 64'(ia.out_valid), 64'h0);

    // fill, stall, drain
    ia.out_ready = 1'b0;
    iss_a(OP, 3'b000, 7'h00, 32'd10, 32'd20, 32'h0, 7'd4, 4'd4);
    tick;
    chk("fill_irdy1", 64'(ia.issue_ready), 64'h1);
    iss_a(OP, 3'b100, 7'h00, 32'hF0, 32'hFF, 32'h0, 7'd5, 4'd5);
    tick;
    iss_a(OP, 3'b110, 7'h00, 32'h100, 32'h001, 32'h0, 7'd6, 4'd6);
    chk("stall_irdy", 64'(ia.issue_ready), 64'h0);
    chk("stall_data0", 64'(ia.out_data), 64'd30);
    tick;
    chk("stall_data1", 64'(ia.out_data), 64'd30);
    chk("stall_pd1", 64'(ia.out_pd), 64'd4);
    chk("stall_irdy1", 64'(ia.issue_ready), 64'h0);
    tick;
    chk("stall_data2", 64'(ia.out_data), 64'd30);
    chk("stall_valid2", 64'(ia.out_valid), 64'h1);
    ia.out_ready = 1'b1;
    #1;
    chk("release_irdy", 64'(ia.issue_ready), 64'h1);
    tick;
    chk("drain_y", 64'(ia.out_data), 64'h0F);
    chk("drain_y_pd", 64'(ia.out_pd), 64'd5);
    ia.issue_valid = 1'b0;
    tick;
    chk("drain_z", 64'(ia.out_data), 64'h101);
    chk("drain_z_pd", 64'(ia.out_pd), 64'd6);
    tick;
    chk("drain_empty", 64'(ia.out_valid), 64'h0);

    // flush with two in flight plus a same-edge issue
    ia.out_ready = 1'b0;
    iss_a(OP, 3'b000, 7'h00, 32'd3, 32'd4, 32'h0, 7'd7, 4'd7);
    tick;
    iss_a(OP, 3'b000, 7'h00, 32'd5, 32'd6, 32'h0, 7'd8, 4'd8);
    tick;
    chk("pre_flush_v", 64'(ia.out_valid), 64'h1);
    iss_a(OP, 3'b000, 7'h00, 32'd9, 32'd9, 32'h0, 7'd10, 4'd10);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    ia.issue_valid = 1'b0;
    chk("flush_v0", 64'(ia.out_valid), 64'h0);
    ia.out_ready = 1'b1;
    tick;
    chk("flush_v1", 64'(ia.out_valid), 64'h0);
    tick;
    chk("flush_v2", 64'(ia.out_valid), 64'h0);
    iss_a(OP, 3'b000, 7'h00, 32'd1, 32'd1, 32'h0, 7'd9, 4'd9);
    tick;
    chk("post_flush_early", 64'(ia.out_valid), 64'h0);
    ia.issue_valid = 1'b0;
    tick;
    chk("post_flush_v", 64'(ia.out_valid), 64'h1);
    chk("post_flush_d", 64'(ia.out_data), 64'h2);
    chk("post_flush_rob", 64'(ia.out_rob), 64'd9);
    tick;

    // AUIPC, LUI, unsupported opcode
    ia.pc = 32'h1000;
    iss_a(AUIPC, 3'b000, 7'h00, 32'h0, 32'h0, 32'h2000, 7'd1, 4'd1);
    tick;
    ia.pc = 32'h0;
    iss_a(LUI, 3'b000, 7'h00, 32'h55, 32'h66, 32'hABCD_E000, 7'd2, 4'd2);
    tick;
    chk("auipc", 64'(ia.out_data), 64'h3000);
    iss_a(7'h7F, 3'b000, 7'h00, 32'h5, 32'h6, 32'h7, 7'd11, 4'd12);
    tick;
    chk("lui", 64'(ia.out_data), 64'hABCD_E000);
    ia.issue_valid = 1'b0;
    tick;
    chk("unsup_v", 64'(ia.out_valid), 64'h1);
    chk("unsup_d", 64'(ia.out_data), 64'h0);
    chk("unsup_pd", 64'(ia.out_pd), 64'd11);
    chk("unsup_rob", 64'(ia.out_rob), 64'd12);
    tick;
    chk("unsup_pulse", 64'(ia.out_valid), 64'h0);

    // op table
    for (int i = 0; i < 17; i++) begin
      iss_a(tv[i].op, tv[i].f3, tv[i].f7, tv[i].a, tv[i].b,
            tv[i].im, 7'(i + 16), 4'(i));
      tick;
      ia.issue_valid = 1'b0;
      tick;
      chk($sformatf("vec%0d", i), 64'(ia.out_data), 64'(tv[i].exp));
    end
    tick;

    // 64-bit, 4-stage SLLI
    iss_b(3'b001, 64'h1, 64'd63, 7'd11, 4'd5);
    tick;
    ib.issue_valid = 1'b0;
    chk("b_lat1", 64'(ib.out_valid), 64'h0);
    tick;
    chk("b_lat2", 64'(ib.out_valid), 64'h0);
    tick;
    chk("b_lat3", 64'(ib.out_valid), 64'h0);
    tick;
    chk("b_slli_v", 64'(ib.out_valid), 64'h1);
    chk("b_slli_d", ib.out_data, 64'h8000_0000_0000_0000);
    chk("b_slli_pd", 64'(ib.out_pd), 64'd11);
    tick;
    chk("b_gone", 64'(ib.out_valid), 64'h0);

    // async reset with ops in flight on both copies
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    iss_a(OP, 3'b000, 7'h00, 32'd2, 32'd3, 32'h0, 7'd20, 4'd1);
    iss_b(3'b000, 64'd7, 64'd8, 7'd21, 4'd2);
    tick;
    iss_a(OP, 3'b000, 7'h00, 32'd4, 32'd5, 32'h0, 7'd22, 4'd3);
    iss_b(3'b000, 64'd9, 64'd1, 7'd23, 4'd4);
    tick;
    ia.issue_valid = 1'b0;
    ib.issue_valid = 1'b0;
    tick;
    tick;
    chk("pre_rst_a_v", 64'(ia.out_valid), 64'h1);
    chk("pre_rst_b_v", 64'(ib.out_valid), 64'h1);
    chk("pre_rst_b_d", ib.out_data, 64'd15);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_a_v", 64'(ia.out_valid), 64'h0);
    chk("mid_rst_a_d", 64'(ia.out_data), 64'h0);
    chk("mid_rst_a_pd", 64'(ia.out_pd), 64'h0);
    chk("mid_rst_a_ir", 64'(ia.issue_ready), 64'h1);
    chk("mid_rst_b_v", 64'(ib.out_valid), 64'h0);
    chk("mid_rst_b_d", ib.out_data, 64'h0);
    chk("mid_rst_b_rob", 64'(ib.out_rob), 64'h0);
    chk("mid_rst_b_ir", 64'(ib.issue_ready), 64'h1);
    tick;
    reset = 1'b1;
    tick;
    chk("post_rst_a_v", 64'(ia.out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
Parametrised, elastic, multi-stage integer ALU functional unit for the out-of-order core. It is the successor to the single-cycle ALU FU and adds:
- the full RV32I OP/OP-IMM/LUI/AUIPC set
- configurable data width and pipeline depth
- valid/ready backpressure toward the CDB arbiter
- pipeline flush on branch mispredict

It sits between RS/PRF read and the writeback/CDB arbiter.

Parameters:
XLEN, 32, data width of operands and result (power of two, >=8).
STAGES, 2, pipeline depth = issue-to-result latency in cycles (1..4).
PREG_W, 7, physical register tag width.
ROB_W, 4, ROB index width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
flush  in  1  kill all in-flight ops (mispredict recovery).
issue_valid  in  1  op presented by RS/PRF this cycle.
issue_ready  out  1  FU accepts op this cycle.
opcode  in  7  instruction opcode.
func3  in  3  instruction func3.
func7  in  7  instruction func7.
imm  in  XLEN  sign-extended immediate (LUI: already shifted).
pc  in  XLEN  instruction PC (AUIPC only).
ps1_data  in  XLEN  source 1 value.
ps2_data  in  XLEN  source 2 value.
pd  in  PREG_W  destination physical register.
rob_idx  in  ROB_W  ROB entry of op.
out_valid  out  1  result valid at last stage.
out_ready  in  1  arbiter consumes result this cycle.
out_pd  out  PREG_W  destination tag of result.
out_rob  out  ROB_W  ROB index of result.
out_data  out  XLEN  result value.

Behaviour:
- Reset (reset=0, async): all stage valid bits 0; out_pd, out_rob, out_data = 0; out_valid = 0. issue_ready is combinational and therefore reads 1 while reset is held.
- Pipeline structure:
  - Stage 1 captures tag, ROB index and computed result.
  - Stages 2..STAGES are pure register stages.
  - out_* are driven directly from the last stage registers.
- Advance rule:
  - last stage advances when !v[last] or out_ready;
  - stage i advances when !v[i] or stage i+1 advances;
  - issue_ready = stage-1 advance condition.
- Handshakes:
  - Transfer in occurs on issue_valid && issue_ready.
  - Transfer out occurs on out_valid && out_ready.
  - A stalled stage holds its contents unchanged.
  - A bubble propagates as valid = 0.
- Latency: exactly STAGES cycles from accepting edge to out_valid with out_ready held 1. Throughput is 1 op/cycle. Simultaneous in and out on a full pipe is allowed (no bubble inserted).
- Operations: result is computed combinationally before stage 1. Shift amount = low log2(XLEN) bits of the operand.
  - OP-IMM 0010011:
    - ADDI 000
    - SLTI 010 (signed)
    - SLTIU 011 (unsigned)
    - XORI 100
    - ORI 110
    - ANDI 111
    - SLLI 001
    - SRLI 101/func7[5]=0
    - SRAI 101/func7[5]=1
  - OP 0110011:
    - ADD/SUB 000 (func7[5] selects SUB)
    - SLL 001
    - SLT 010
    - SLTU 011
    - XOR 100
    - SRL/SRA 101
    - OR 110
    - AND 111
  - LUI 0110111: result = imm.
  - AUIPC 0010111: result = pc + imm.
  - SLT* results are zero-extended 0/1.
  - Add/sub wrap modulo 2^XLEN.
  - Unsupported opcode: result 0; op still completes with its pd/rob.
- Flush:
  - Synchronous; takes priority over everything.
  - At the edge where flush=1, all valid bits clear.
  - An op handshaken on the same edge is discarded.
  - out_valid = 0 the cycle after.
  - Data registers may keep stale values.
- Stall with out_valid=1 and out_ready=0: out_pd, out_rob and out_data remain stable until the handshake.
- Reset asserted mid-operation: all in-flight ops are lost immediately (asynchronously); no partial output.

Test Plan:
- STAGES=2: ADDI ps1=0x0000_0005, imm=0xFFFF_FFFD, pd=12, rob=3 -> out_valid 2 cycles later, out_data=0x2, out_pd=12, out_rob=3.
- Back-to-back SUB 7-9, SRA 0x8000_0000>>>4, SLTU 1<0xFFFF_FFFF on consecutive cycles, out_ready=1 -> results 0xFFFF_FFFE, 0xF800_0000, 0x1 on consecutive cycles, in issue order.
- Fill pipe (STAGES=2), hold out_ready=0 for 3 cycles:
  - issue_ready=0 once both stages are valid;
  - out_data stable;
  - releasing out_ready drains one op/cycle, with issue accepted the same cycle.
- flush asserted with 2 ops in flight and issue_valid=1 -> no out_valid for those 3 ops; next ADD 1+1 issued after flush -> out_data=0x2 at nominal latency.
- AUIPC pc=0x1000, imm=0x0000_2000 -> 0x3000; LUI imm=0xABCD_E000 -> 0xABCD_E000; opcode 0x7F -> out_data=0, out_valid pulses.
- Drive reset=0 with 2 ops in flight and out_ready=0 -> out_valid drops immediately, outputs 0, issue_ready=1; repeat with XLEN=64, STAGES=4: SLLI 1<<63 -> 0x8000_0000_0000_0000 after 4 cycles.
